fetch_ifid_stage: RTL and testbench
===================================

// Module: fetch_ifid_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register for the 16-bit, 16-register pipelined CPU.
//  Holds the PC, drives the instruction-memory address, and latches the fetched word into IF/ID.
//  Decodes the register fields and the branch/store flags that hazard detection needs.
//  Consumes NoOp (stall) from hazard detection and BranchTaken/BranchTarget (flush) from branch resolution.
// PARAMETERS
//  PC_W      16      PC / address width; the PC increments by 2 (byte-addressed 16-bit words)
//  RESET_PC  16'h0   PC value loaded on reset
//  NOP_WORD  16'h0   instruction word placed in IF/ID on a bubble (ADD R0,R0,R0)
// PORTS
//  clk            in   1     system clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  NoOp           in   1     stall request from hazard detection: hold the PC and IF/ID
//  BranchTaken    in   1     taken branch resolved: flush IF/ID and redirect the PC
//  BranchTarget   in   PC_W  redirect address, valid when BranchTaken=1
//  imem_addr      out  PC_W  instruction-memory address (= PC, combinational)
//  imem_data      in   16    instruction word at imem_addr, same cycle (async read)
//  IFIDinstr      out  16    latched instruction
//  IFIDpc2        out  PC_W  latched PC+2 of that instruction
//  IFIDvalid      out  1     1 = IF/ID holds a real instruction, 0 = bubble
//  IFIDrd         out  4     IFIDinstr[11:8]
//  IFIDrs         out  4     IFIDinstr[7:4]
//  IFIDrt         out  4     IFIDinstr[3:0]
//  IFIDBranch     out  1     valid & opcode in {4'hC B, 4'hD BR}
//  IFIDMemWrite   out  1     valid & opcode == 4'h9 (SW)
//  halted         out  1     1 while the FSM is in HALTED
// BEHAVIOUR
//  Reset: PC=RESET_PC, IFIDinstr=NOP_WORD, IFIDpc2=0, IFIDvalid=0, state=RUN, halted=0.
//   All decoded outputs are 0. Reset overrides every other input.
//  Per-cycle priority (non-reset): BranchTaken > NoOp > halt logic > normal fetch.
//  Normal (RUN): IFIDinstr<=imem_data, IFIDpc2<=PC+2, IFIDvalid<=1, PC<=PC+2.
//   The PC wraps modulo 2^PC_W; there is no overflow flag.
//  Stall (NoOp=1, BranchTaken=0): PC and every IF/ID register hold, in any state.
//  Flush (BranchTaken=1): PC<=BranchTarget, IFIDinstr<=NOP_WORD, IFIDvalid<=0, state<=RUN.
//   Flush applies even when NoOp=1 in the same cycle.
//  Decoded outputs are combinational from the IF/ID registers and are 0 when IFIDvalid=0.
//   This holds so bubbles never create hazards.
//  FSM states: RUN, HALTED.
//   RUN -> HALTED: when a word with opcode 4'hF (HLT) is fetched with no stall and no flush.
//    The HLT word is latched into IF/ID (valid=1), and the PC holds at the HLT address (no +2).
//   HALTED: the PC holds. Each non-stalled cycle loads a bubble (NOP_WORD, valid=0) so HLT drains downstream.
//   HALTED -> RUN: only on BranchTaken (the HLT sat in the shadow of a taken branch) or on rst.
//  The IF/ID output registers are 1-deep; there is no skid. The upstream address is always recomputable from PC.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0].
//   Both are zeroed by rst and saturate at 16'hFFFF.
//   stall_cnt increments on cycles with NoOp=1 & BranchTaken=0.
//   flush_cnt increments on cycles with BranchTaken=1.
//  IF_PERF_CNT_EN undefined: neither port nor counter exists. All other behaviour is identical.
// TESTING
//  1 Reset, then imem returns 16'h1234, 16'h2345 -> cycle 1: IFIDinstr=1234, IFIDpc2=2, PC=2;
//    cycle 2: IFIDinstr=2345, IFIDpc2=4, PC=4.
//  2 IF/ID holds 16'h9A31 (SW), NoOp=1 for 2 cycles -> PC and IFIDinstr unchanged for 2 cycles;
//    IFIDMemWrite=1, rd=A, rs=3, rt=1; the fetch resumes at the same PC.
//  3 BranchTaken=1, BranchTarget=16'h0040, NoOp=1 in the same cycle -> next cycle: PC=0x40, IFIDvalid=0,
//    IFIDBranch=0, IFIDrs=IFIDrt=IFIDrd=0; with IF_PERF_CNT_EN, flush_cnt +1 and stall_cnt +0.
//  4 Fetch 16'hF000 at PC=0x10 -> IF/ID holds F000 (valid=1), halted=1, PC stays 0x10;
//    the following cycles give bubbles, valid=0.
//  5 In HALTED, BranchTaken=1 with target 0x20 -> state RUN, halted=0, PC=0x20, normal fetch resumes.
//  6 PC=16'hFFFE, normal fetch -> PC wraps to 0x0000, IFIDpc2=0x0000;
//    rst asserted mid-stall -> every reset value is restored next cycle.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Fetch/IF-ID bus: hazard-control inputs, instruction-memory port and the latched IF/ID view.
// The master modport is the fetch stage; the slave modport is the surrounding pipeline/memory.
interface fetch_ifid_if #(parameter int PC_W = 16);
  logic            NoOp;
  logic            BranchTaken;
  logic [PC_W-1:0] BranchTarget;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [15:0]     IFIDinstr;
  logic [PC_W-1:0] IFIDpc2;
  logic            IFIDvalid;
  logic [3:0]      IFIDrd;
  logic [3:0]      IFIDrs;
  logic [3:0]      IFIDrt;
  logic            IFIDBranch;
  logic            IFIDMemWrite;
  logic            halted;

  modport master (
    input  NoOp, BranchTaken, BranchTarget, imem_data,
    output imem_addr, IFIDinstr, IFIDpc2, IFIDvalid, IFIDrd, IFIDrs, IFIDrt,
           IFIDBranch, IFIDMemWrite, halted
  );

  modport slave (
    output NoOp, BranchTaken, BranchTarget, imem_data,
    input  imem_addr, IFIDinstr, IFIDpc2, IFIDvalid, IFIDrd, IFIDrs, IFIDrt,
           IFIDBranch, IFIDMemWrite, halted
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch stage + IF/ID register for the 16-bit CPU, with a RUN/HALTED FSM for HLT draining.
// Optional IF_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module fetch_ifid_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  fetch_ifid_if.master      bus
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [PC_W-1:0] r_pc2, w_pc2_nxt;
  logic [15:0]     r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic [3:0]      w_op;
  logic            w_fetch_hlt;

  assign w_pc_inc    = r_pc + PC_W'(2);
  assign w_fetch_hlt = (bus.imem_data[15:12] == 4'hF);

  // Priority: flush > stall > halted bubble > fetch (HLT parks the PC on itself).
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pc2_nxt   = r_pc2;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    if (bus.BranchTaken) begin
      w_pc_nxt    = bus.BranchTarget;
      w_instr_nxt = NOP_WORD;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_RUN;
    end else if (bus.NoOp) begin
      w_state_nxt = r_state;
    end else if (r_state == S_HALTED) begin
      w_instr_nxt = NOP_WORD;
      w_valid_nxt = 1'b0;
    end else begin
      w_instr_nxt = bus.imem_data;
      w_pc2_nxt   = w_pc_inc;
      w_valid_nxt = 1'b1;
      if (w_fetch_hlt) w_state_nxt = S_HALTED;
      else             w_pc_nxt    = w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_pc2   <= '0;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pc2   <= w_pc2_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.NoOp && !bus.BranchTaken && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (bus.BranchTaken && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  // Decode is masked by valid so bubbles never look like hazards.
  assign w_op             = r_instr[15:12];
  assign bus.imem_addr    = r_pc;
  assign bus.IFIDinstr    = r_instr;
  assign bus.IFIDpc2      = r_pc2;
  assign bus.IFIDvalid    = r_valid;
  assign bus.IFIDrd       = r_valid ? r_instr[11:8] : 4'h0;
  assign bus.IFIDrs       = r_valid ? r_instr[7:4]  : 4'h0;
  assign bus.IFIDrt       = r_valid ? r_instr[3:0]  : 4'h0;
  assign bus.IFIDBranch   = r_valid && (w_op == 4'hC || w_op == 4'hD);
  assign bus.IFIDMemWrite = r_valid && (w_op == 4'h9);
  assign bus.halted       = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: directed scenarios then random stall/flush/reset traffic.
// Expected IF/ID state comes from a spec-level model fed by the same instruction memory image.
module tb_fetch_ifid_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ifid_if #(.PC_W(16)) ifc ();

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  fetch_ifid_stage #(.PC_W(16), .RESET_PC(16'h0000), .NOP_WORD(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
`ifdef IF_PERF_CNT_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .bus(ifc.master)
  );

  logic [15:0] mem [0:32767];
  assign ifc.imem_data = mem[ifc.imem_addr[15:1]];

  typedef struct {
    logic [15:0] pc, instr, pc2;
    logic        valid, halted, br, mw;
    logic [3:0]  rd, rs, rt;
    logic [15:0] scnt, fcnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_pc2, m_scnt, m_fcnt;
  logic        m_valid, m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    logic [3:0] op;
    op       = m_instr[15:12];
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.pc2    = m_pc2;
    e.valid  = m_valid;
    e.halted = m_halt;
    e.rd     = m_valid ? m_instr[11:8] : 4'h0;
    e.rs     = m_valid ? m_instr[7:4]  : 4'h0;
    e.rt     = m_valid ? m_instr[3:0]  : 4'h0;
    e.br     = m_valid && (op == 4'hC || op == 4'hD);
    e.mw     = m_valid && (op == 4'h9);
    e.scnt   = m_scnt;
    e.fcnt   = m_fcnt;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then queue the expectation.
  task automatic step(input bit r, input bit n, input bit b, input logic [15:0] t);
    logic [15:0] word;
    rst = r;
    ifc.NoOp = n;
    ifc.BranchTaken = b;
    ifc.BranchTarget = t;
    word = mem[m_pc[15:1]];
    if (r) begin
      m_pc = 16'h0; m_instr = 16'h0; m_pc2 = 16'h0; m_valid = 0; m_halt = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (b) begin
      m_pc = t; m_instr = 16'h0; m_valid = 0; m_halt = 0;
      if (m_fcnt != 16'hFFFF) m_fcnt++;
    end else if (n) begin
      if (m_scnt != 16'hFFFF) m_scnt++;
    end else if (m_halt) begin
      m_instr = 16'h0; m_valid = 0;
    end else begin
      m_instr = word; m_pc2 = m_pc + 16'd2; m_valid = 1;
      if (word[15:12] == 4'hF) m_halt = 1;
      else m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
    q.push_back(snap());
  endtask

  // Monitor: the DUT presents a fresh IF/ID state every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", 32'(ifc.imem_addr), 32'(e.pc));
        chk("IFIDinstr", 32'(ifc.IFIDinstr), 32'(e.instr));
        chk("IFIDvalid", 32'(ifc.IFIDvalid), 32'(e.valid));
        if (e.valid) chk("IFIDpc2", 32'(ifc.IFIDpc2), 32'(e.pc2));
        chk("IFIDrd", 32'(ifc.IFIDrd), 32'(e.rd));
        chk("IFIDrs", 32'(ifc.IFIDrs), 32'(e.rs));
        chk("IFIDrt", 32'(ifc.IFIDrt), 32'(e.rt));
        chk("IFIDBranch", 32'(ifc.IFIDBranch), 32'(e.br));
        chk("IFIDMemWrite", 32'(ifc.IFIDMemWrite), 32'(e.mw));
        chk("halted", 32'(ifc.halted), 32'(e.halted));
`ifdef IF_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
`endif
      end
    end
  end

  initial begin
    logic [15:0] w, tgt;
    ifc.NoOp = 0; ifc.BranchTaken = 0; ifc.BranchTarget = 16'h0;
    m_pc = 0; m_instr = 0; m_pc2 = 0; m_valid = 0; m_halt = 0; m_scnt = 0; m_fcnt = 0;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      // Keep the directed region and the wrap point free of stray HLTs.
      if ((i < 64 || i == 32767) && w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'h1234;
    mem[1] = 16'h2345;
    mem[2] = 16'h9A31;
    mem[8] = 16'hF000;

    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);              // 1234, pc2=2
    step(0, 0, 0, 16'h0);              // 2345, pc2=4
    step(0, 0, 0, 16'h0);              // SW 9A31 latched
    step(0, 1, 0, 16'h0);              // stall holds
    step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0040);           // flush wins over stall
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0010);
    step(0, 0, 0, 16'h0);              // fetch F000 -> halted
    step(0, 0, 0, 16'h0);              // bubbles while halted
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0020);           // leave HALTED
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 16'h0);              // PC wraps to 0
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);              // reset mid-stall
    step(0, 0, 0, 16'h0);

    for (int k = 0; k < 3000; k++) begin
      tgt = {16'($urandom)} & 16'hFFFE;
      if ($urandom_range(0, 7) == 0) tgt = 16'hFFFE;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 12, tgt);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
